// File: rtl/wf68k30l_prefetch_queue.sv
// Instruction prefetch queue: issues longword program fetches, buffers the
// returned 16-bit words in a circular queue and presents the three oldest
// words (plus a bus-error tag on the head) to the opcode decoder.
module wf68k30l_prefetch_queue #(
    parameter int DEPTH_W = 8
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        sbit_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_adr_o,
    output logic [2:0]  fetch_fc_o,
    input  logic        fetch_ack_i,
    input  logic        fetch_berr_i,
    input  logic [31:0] fetch_data_i,
    input  logic [1:0]  consume_i,
    output logic [15:0] opw0_o,
    output logic [15:0] opw1_o,
    output logic [15:0] opw2_o,
    output logic [1:0]  opw_cnt_o,
    output logic        opw_fault_o,
    output logic [31:0] pc_head_o
);

    localparam int PTR_W = $clog2(DEPTH_W);
    localparam int CNT_W = $clog2(DEPTH_W + 1);
    localparam logic [2:0] FC_USER_PROG  = 3'b010;
    localparam logic [2:0] FC_SUPER_PROG = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Fetch control
    state_t            state_q;
    logic              req_q;
    logic [31:0]       adr_q;
    logic [2:0]        fc_q;
    logic [31:0]       fetch_pc_q;
    logic              skip_hi_q;
    logic              halted_q;

    // Queue storage and bookkeeping
    logic [15:0]       word_q [DEPTH_W];
    logic [15:0]       word_d [DEPTH_W];
    logic [DEPTH_W-1:0] fault_q;
    logic [DEPTH_W-1:0] fault_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       pc_head_q, pc_head_d;

    // Registered decoder-side outputs
    logic [15:0]       opw0_q, opw1_q, opw2_q;
    logic [1:0]        opw_cnt_q;
    logic              opw_fault_q;

    logic              completion;
    logic              accept;
    logic              issue;
    logic [CNT_W-1:0]  push_n;
    logic [CNT_W-1:0]  popped;
    logic [PTR_W-1:0]  tail_p1;
    logic [PTR_W-1:0]  head_d1, head_d2;

    // Queue next-state: pops clamped to occupancy, pushes from an accepted fetch, flush wins
    always_comb begin
        completion = (state_q != IDLE) && (fetch_ack_i || fetch_berr_i);
        accept     = (state_q == BUSY) && completion && !flush_i;
        push_n     = accept ? (skip_hi_q ? CNT_W'(1) : CNT_W'(2)) : CNT_W'(0);
        popped     = (CNT_W'(consume_i) > count_q) ? count_q : CNT_W'(consume_i);
        tail_p1    = tail_q + PTR_W'(1);

        word_d  = word_q;
        fault_d = fault_q;
        if (accept) begin
            if (skip_hi_q) begin
                word_d[tail_q]  = fetch_berr_i ? 16'h0000 : fetch_data_i[15:0];
                fault_d[tail_q] = fetch_berr_i;
            end else begin
                word_d[tail_q]   = fetch_berr_i ? 16'h0000 : fetch_data_i[31:16];
                fault_d[tail_q]  = fetch_berr_i;
                word_d[tail_p1]  = fetch_berr_i ? 16'h0000 : fetch_data_i[15:0];
                fault_d[tail_p1] = fetch_berr_i;
            end
        end

        if (flush_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pc_head_d = flush_pc_i;
        end else begin
            head_d    = head_q + PTR_W'(popped);
            tail_d    = tail_q + PTR_W'(push_n);
            count_d   = count_q - popped + push_n;
            pc_head_d = pc_head_q + (32'(popped) << 1);
        end

        head_d1 = head_d + PTR_W'(1);
        head_d2 = head_d + PTR_W'(2);

        // A new request needs room for a full longword after this clock's push/pop
        issue = (state_q == IDLE) && !flush_i && !halted_q &&
                (count_d <= CNT_W'(DEPTH_W - 2));
    end

    // Fetch FSM: request/address/function code held stable for the whole bus cycle
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            adr_q      <= 32'h0000_0000;
            fc_q       <= FC_SUPER_PROG;
            fetch_pc_q <= 32'h0000_0000;
            skip_hi_q  <= 1'b0;
            halted_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= BUSY;
                        req_q   <= 1'b1;
                        adr_q   <= fetch_pc_q;
                        fc_q    <= sbit_i ? FC_SUPER_PROG : FC_USER_PROG;
                    end
                end
                BUSY: begin
                    if (completion) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else if (flush_i) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (completion) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase

            if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                skip_hi_q  <= 1'b0;
                if (fetch_berr_i) begin
                    halted_q <= 1'b1;
                end
            end

            if (flush_i) begin
                fetch_pc_q <= {flush_pc_i[31:2], 2'b00};
                skip_hi_q  <= flush_pc_i[1];
                halted_q   <= 1'b0;
            end
        end
    end

    // Queue pointers, occupancy and head program counter
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pc_head_q <= 32'h0000_0000;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pc_head_q <= pc_head_d;
        end
    end

    // Word storage; contents beyond the occupancy are never presented as valid
    always_ff @(posedge clk_i) begin
        word_q  <= word_d;
        fault_q <= fault_d;
    end

    // Decoder outputs registered from next-state so pushed words show one clock after ACK
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            opw0_q      <= 16'h0000;
            opw1_q      <= 16'h0000;
            opw2_q      <= 16'h0000;
            opw_cnt_q   <= 2'd0;
            opw_fault_q <= 1'b0;
        end else begin
            opw0_q      <= word_d[head_d];
            opw1_q      <= word_d[head_d1];
            opw2_q      <= word_d[head_d2];
            opw_cnt_q   <= (count_d >= CNT_W'(3)) ? 2'd3 : count_d[1:0];
            opw_fault_q <= (count_d != '0) && fault_d[head_d];
        end
    end

    assign fetch_req_o = req_q;
    assign fetch_adr_o = adr_q;
    assign fetch_fc_o  = fc_q;
    assign opw0_o      = opw0_q;
    assign opw1_o      = opw1_q;
    assign opw2_o      = opw2_q;
    assign opw_cnt_o   = opw_cnt_q;
    assign opw_fault_o = opw_fault_q;
    assign pc_head_o   = pc_head_q;

endmodule
